// File: rtl/tick_arb_pkg.sv
// tick_arb_pkg: shared types and widths for the tick-slot arbiter
package tick_arb_pkg;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
  localparam int SLOT_CNT_W = 8;
endpackage

// File: rtl/tick_slot_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder, scans from ptr+1 circularly
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] win_id,
  output logic [N-1:0] win
);
  logic [W-1:0] w_idx;
  always_comb begin
    found = 1'b0;
    win_id = '0;
    win = '0;
    w_idx = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = W'((int'(ptr) + i) % N);
      if (!found && req[w_idx]) begin
        found = 1'b1;
        win_id = w_idx;
      end
    end
    win[win_id] = found;
  end
endmodule

// File: rtl/tick_slot_arbiter.sv
// tick_slot_arbiter: round-robin time-slot arbiter, slots bounded by a tick strobe
module tick_slot_arbiter
  import tick_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int SLOT_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     slot_end
);
  localparam int W = $clog2(N_REQ);
  localparam logic [SLOT_CNT_W-1:0] LAST = SLOT_CNT_W'(SLOT_TICKS - 1);
  state_t                r_state, w_nxt_state;
  logic [N_REQ-1:0]      r_gnt, w_nxt_gnt;
  logic [W-1:0]          r_gnt_id, w_nxt_gnt_id;
  logic [W-1:0]          r_ptr, w_nxt_ptr;
  logic [SLOT_CNT_W-1:0] r_slot_cnt, w_nxt_slot_cnt;
  logic                  r_slot_end, w_nxt_slot_end;
  logic                  w_found;
  logic [W-1:0]          w_win_id;
  logic [N_REQ-1:0]      w_win;
  logic                  w_expire, w_release, w_start;
  rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .win_id(w_win_id),
    .win   (w_win)
  );
  assign w_expire  = (r_state == ST_GRANT) && tick && (r_slot_cnt == LAST);
  assign w_release = (r_state == ST_GRANT) && !req[r_gnt_id];
  // expiry takes precedence over release; a released owner simply drops out of the scan
  assign w_start   = w_found && (w_expire || ((r_state == ST_IDLE) && tick));
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt = r_gnt;
    w_nxt_gnt_id = r_gnt_id;
    w_nxt_ptr = r_ptr;
    w_nxt_slot_cnt = r_slot_cnt;
    w_nxt_slot_end = w_expire || w_release;
    if (w_start) begin
      w_nxt_state = ST_GRANT;
      w_nxt_gnt = w_win;
      w_nxt_gnt_id = w_win_id;
      w_nxt_ptr = w_win_id;
      w_nxt_slot_cnt = '0;
    end else if (w_expire || w_release) begin
      w_nxt_state = ST_IDLE;
      w_nxt_gnt = '0;
      w_nxt_slot_cnt = '0;
    end else if ((r_state == ST_GRANT) && tick) begin
      w_nxt_slot_cnt = r_slot_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt <= '0;
      r_gnt_id <= '0;
      r_ptr <= W'(N_REQ - 1);
      r_slot_cnt <= '0;
      r_slot_end <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt <= w_nxt_gnt;
      r_gnt_id <= w_nxt_gnt_id;
      r_ptr <= w_nxt_ptr;
      r_slot_cnt <= w_nxt_slot_cnt;
      r_slot_end <= w_nxt_slot_end;
    end
  end
  assign gnt = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy = |r_gnt;
  assign slot_end = r_slot_end;
endmodule

// File: tb/tb_tick_slot_arbiter.sv
// tb_tick_slot_arbiter: directed checks of tick_slot_arbiter with N_REQ=4, SLOT_TICKS=2
module tb_tick_slot_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       slot_end;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] rot [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  always #5 clk = ~clk;
  tick_slot_arbiter #(.N_REQ(4), .SLOT_TICKS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .slot_end(slot_end)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [3:0] g, input logic [1:0] id, input logic se);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    chk({tag, ".slot_end"}, 32'(slot_end), 32'(se));
  endtask
  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    req = '0;
    clk1(1'b0);
    rst = 1'b0;
  endtask
  initial begin
    // reset wins over tick and req
    rst = 1'b1;
    req = 4'b1111;
    clk1(1'b1);
    clk1(1'b1);
    outs("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.slot_cnt", 32'(dut.r_slot_cnt), 32'd0);
    rst = 1'b0;
    clk1(1'b0);
    outs("req_no_tick", 4'b0000, 2'd0, 1'b0);
    clk1(1'b1);
    outs("first_grant", 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (3) clk1(1'b0);
      clk1(1'b1);
      outs("mid_slot", rot[(k + 3) % 4], 2'((k + 3) % 4 == 3 ? 0 : k), 1'b0);
      repeat (3) clk1(1'b0);
      chk("pre_handover.gnt", 32'(gnt), 32'(rot[(k + 3) % 4]));
      clk1(1'b1);
      outs("handover", rot[k], 2'((k + 1) % 4), 1'b1);
    end
    clk1(1'b0);
    outs("after_rotation", 4'b0001, 2'd0, 1'b0);
    // early release
    do_rst();
    req = 4'b0100;
    clk1(1'b1);
    outs("rel_grant", 4'b0100, 2'd2, 1'b0);
    clk1(1'b0);
    clk1(1'b0);
    req = 4'b0000;
    clk1(1'b0);
    outs("rel_drop", 4'b0000, 2'd2, 1'b1);
    clk1(1'b0);
    outs("rel_idle", 4'b0000, 2'd2, 1'b0);
    req = 4'b0001;
    clk1(1'b0);
    outs("rel_wait_tick", 4'b0000, 2'd2, 1'b0);
    clk1(1'b1);
    outs("rel_regrant", 4'b0001, 2'd0, 1'b0);
    // sole requester keeps the resource, late requester waits for boundary
    do_rst();
    req = 4'b0010;
    clk1(1'b1);
    outs("sole_grant", 4'b0010, 2'd1, 1'b0);
    repeat (3) clk1(1'b0);
    clk1(1'b1);
    outs("sole_tick1", 4'b0010, 2'd1, 1'b0);
    repeat (3) clk1(1'b0);
    clk1(1'b1);
    outs("sole_expire", 4'b0010, 2'd1, 1'b1);
    clk1(1'b0);
    outs("sole_after", 4'b0010, 2'd1, 1'b0);
    req = 4'b1010;
    clk1(1'b0);
    clk1(1'b0);
    outs("no_preempt", 4'b0010, 2'd1, 1'b0);
    clk1(1'b1);
    outs("no_preempt_tick", 4'b0010, 2'd1, 1'b0);
    repeat (3) clk1(1'b0);
    clk1(1'b1);
    outs("late_handover", 4'b1000, 2'd3, 1'b1);
    // release coinciding with expiry
    do_rst();
    req = 4'b1010;
    clk1(1'b1);
    outs("rx_grant", 4'b0010, 2'd1, 1'b0);
    repeat (3) clk1(1'b0);
    clk1(1'b1);
    repeat (3) clk1(1'b0);
    req = 4'b1000;
    clk1(1'b1);
    outs("rx_expire", 4'b1000, 2'd3, 1'b1);
    // reset mid-slot
    do_rst();
    req = 4'b0100;
    clk1(1'b1);
    outs("rm_grant", 4'b0100, 2'd2, 1'b0);
    clk1(1'b0);
    clk1(1'b0);
    rst = 1'b1;
    clk1(1'b1);
    outs("rm_reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b0101;
    clk1(1'b0);
    outs("rm_no_pulse", 4'b0000, 2'd0, 1'b0);
    clk1(1'b1);
    outs("rm_regrant", 4'b0001, 2'd0, 1'b0);
    // tick held high
    do_rst();
    req = 4'b0001;
    clk1(1'b1);
    outs("th_grant", 4'b0001, 2'd0, 1'b0);
    chk("th_grant.slot_cnt", 32'(dut.r_slot_cnt), 32'd0);
    clk1(1'b1);
    outs("th_tick2", 4'b0001, 2'd0, 1'b0);
    chk("th_tick2.slot_cnt", 32'(dut.r_slot_cnt), 32'd1);
    clk1(1'b1);
    outs("th_expire", 4'b0001, 2'd0, 1'b1);
    chk("th_expire.slot_cnt", 32'(dut.r_slot_cnt), 32'd0);
    clk1(1'b0);
    outs("th_after", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    clk1(1'b0);
    outs("th_drop", 4'b0000, 2'd0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_slot_arbiter.md
# tick_slot_arbiter

Round-robin time-slot arbiter that shares one downstream resource among `N_REQ` requesters. Slot boundaries come from a periodic one-cycle `tick` strobe, normally the divide-by-4 strobe from the clock divider. A grant starts only on a tick and lasts `SLOT_TICKS` ticks, unless the owner releases it early. The block sits between the requesters and the shared resource's enable/select mux.

## Interface
- `N_REQ`, default 4, number of requesters; legal range 2..16.
- `SLOT_TICKS`, default 2, slot length in ticks; legal range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  in  1  slot-boundary strobe, one cycle wide, no fixed period required.
- `req`  in  `N_REQ`  level requests; bit i is held high while requester i wants the resource.
- `gnt`  out  `N_REQ`  registered one-hot grant, or all zeros.
- `gnt_id`  out  `$clog2(N_REQ)`  index of the current or most recent owner.
- `busy`  out  1  equals `|gnt`.
- `slot_end`  out  1  one-cycle pulse in the first cycle after a grant ends or changes owner.

## Operation
- **State machine:** two states, IDLE and GRANT.
- **Internal registers:**
  - `ptr`: last owner index; reset value `N_REQ-1`, so requester 0 has top priority after reset.
  - `slot_cnt`: 8-bit tick counter.
- **Winner selection:** scan circularly from `ptr+1` and take the first asserted `req` bit.
- **IDLE → GRANT:** in a cycle with `tick=1` and `|req=1`, register the winner into `gnt` and `gnt_id`, set `ptr` to the winner and clear `slot_cnt`. `req` without `tick` has no effect.
- **GRANT, tick without expiry:** when `tick=1` and `slot_cnt < SLOT_TICKS-1`, increment `slot_cnt`.
- **GRANT, expiry:** when `tick=1` and `slot_cnt == SLOT_TICKS-1`, the slot expires.
  - If `|req=1`, hand over back-to-back to a new winner, computed from the updated `ptr`.
  - The owner may win again only if it is the sole requester.
  - If `|req=0`, go to IDLE with `gnt=0`.
  - In both cases, pulse `slot_end`.
- **GRANT, release:** the owner dropping `req[gnt_id]` releases the slot.
  - Next cycle: `gnt=0`, `slot_end=1`, state IDLE.
  - A new grant starts only on a later tick.
- **Release coinciding with expiry:** treat as expiry. The owner's low `req` excludes it from the scan.
- **Non-owner requests during GRANT:** ignored until the next slot boundary. No preemption.
- **`gnt_id` after a grant ends:** holds the last owner.

## Timing
- **Reset values:** `gnt=0`, `gnt_id=0`, `busy=0`, `slot_end=0`, `slot_cnt=0`, `ptr=N_REQ-1`, state IDLE.
- **Reset priority:** reset wins over `tick` and `req` in the same cycle. Reset during GRANT drops `gnt` the cycle after `rst` is sampled, with no `slot_end` pulse.
- **Grant latency:** 1 clk from the tick cycle. `gnt`, `gnt_id` and `busy` change together on the clock edge that samples the tick.
- **Release latency:** 1 clk from `req[gnt_id]` falling.
- **Slot length:** with a fixed tick period P, a full slot lasts `SLOT_TICKS·P` clk.
- **Handover:** `gnt` switches one-hot to one-hot in a single edge, with no zero gap; `slot_end` pulses in that same first cycle.
- **Tick held high:** every cycle counts as a separate tick.
- **`slot_cnt` range:** never exceeds `SLOT_TICKS-1`. With `SLOT_TICKS=1`, every tick in GRANT is an expiry.

## Structure
- **Package `tick_arb_pkg`:**
  - state enum `{ST_IDLE, ST_GRANT}`;
  - `SLOT_CNT_W = 8`.
- **Sub-module `rr_pick`:** combinational rotating priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `win_id`, one-hot `win`.
  - Reusable by other arbiters.
- **Top level:** FSM, `slot_cnt`, `ptr` and output registers.

## Test plan
All scenarios use `N_REQ=4`, `SLOT_TICKS=2`, tick every 4 clk.
- **Reset priority:** after reset, `req=4'b1111`, first tick → `gnt=4'b0001` 1 clk later; grants rotate 0001→0010→0100→1000→0001 with 8 clk per slot and no zero gap; `slot_end` pulses at each handover.
- **Early release:** `req=4'b0100` only, owner drops `req[2]` 3 clk into its slot → `gnt=0` and `slot_end=1` 1 clk later; `req[0]` asserted next is granted only at the following tick.
- **Sole requester:** `req=4'b0010` held → after 2 ticks, `slot_end` pulses and `gnt` stays `4'b0010`; `req[3]` rising mid-slot is not granted until the slot boundary, then `gnt=4'b1000`.
- **Release at expiry:** owner 1 drops `req` in the expiry-tick cycle while `req[3]=1` → next cycle `gnt=4'b1000`, `slot_end=1`.
- **Reset mid-slot:** assert `rst` 2 clk into a grant of requester 2 → all outputs at reset values next cycle, no `slot_end`; with `req=4'b0101` afterwards, requester 0 is granted first.
- **Tick held high:** with `req=4'b0001` and tick held high for 3 clk → the grant starts and expires after 2 ticks; `slot_cnt` never reaches 2.
